// File: rtl/csa_pipelined_adder_pkg.sv
// Shared defaults and parameter legality helper for the pipelined carry-select adder.
package csa_pipelined_adder_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_BLOCK  = 8;
    localparam int DEF_STAGES = 4;

    function automatic bit csa_params_legal(input int width, input int block, input int stages);
        bit ok_s;
        if (block < 1 || stages < 1 || width < block) begin
            ok_s = 1'b0;
        end else if ((width % block) != 0) begin
            ok_s = 1'b0;
        end else if (((width / block) % stages) != 0) begin
            ok_s = 1'b0;
        end else begin
            ok_s = 1'b1;
        end
        return ok_s;
    endfunction

endpackage

// File: rtl/csa_pipelined_adder_block.sv
// One carry-select block: two ripple adders for carry-in 0 and 1, muxed by the real carry.
module csa_pipelined_adder_block
    import csa_pipelined_adder_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK:0]   c0_s;
    logic [BLOCK:0]   c1_s;
    logic [BLOCK-1:0] s0_s;
    logic [BLOCK-1:0] s1_s;

    // Speculative ripple chains; the incoming carry only reaches the final mux.
    always_comb begin
        c0_s    = '0;
        c1_s    = '0;
        s0_s    = '0;
        s1_s    = '0;
        c0_s[0] = 1'b0;
        c1_s[0] = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            s0_s[i]   = a[i] ^ b[i] ^ c0_s[i];
            c0_s[i+1] = (a[i] & b[i]) | (c0_s[i] & (a[i] ^ b[i]));
            s1_s[i]   = a[i] ^ b[i] ^ c1_s[i];
            c1_s[i+1] = (a[i] & b[i]) | (c1_s[i] & (a[i] ^ b[i]));
        end
    end

    assign sum  = cin ? s1_s : s0_s;
    assign cout = cin ? c1_s[BLOCK] : c0_s[BLOCK];

endmodule

// File: rtl/csa_pipelined_adder.sv
// Pipelined carry-select adder/subtractor: each stage resolves a slice of blocks and
// registers the finished low sum bits alongside the still-pending upper operand bits.
module csa_pipelined_adder
    import csa_pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int BLOCK  = DEF_BLOCK,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NBLK        = WIDTH / BLOCK;
    localparam int BLK_PER_STG = NBLK / STAGES;
    localparam int SW          = BLK_PER_STG * BLOCK;

    if (!csa_params_legal(WIDTH, BLOCK, STAGES)) begin : g_bad_params
        $error("csa_pipelined_adder: illegal WIDTH/BLOCK/STAGES combination");
    end

    logic             adv_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;

    assign adv_s     = ~out_valid | out_ready;
    assign in_ready  = adv_s & rst_n;
    assign b_eff_s   = sub ? ~b : b;
    assign cin_eff_s = sub ? ~c_in : c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO  = k * SW;
        localparam int REM = WIDTH - LO;

        logic                 valid_in_s;
        logic                 carry_in_s;
        logic [WIDTH-1:0]     word_in_s;
        logic [WIDTH-1:0]     word_d_s;
        logic [REM-1:0]       b_in_s;
        logic [SW-1:0]        stg_sum_s;
        logic [BLK_PER_STG:0] cy_s;
        logic                 valid_r;
        logic                 carry_r;
        logic [WIDTH-1:0]     word_r;

        if (k == 0) begin : g_first
            assign valid_in_s = in_valid;
            assign carry_in_s = cin_eff_s;
            assign word_in_s  = a;
            assign b_in_s     = b_eff_s;
        end else begin : g_next
            assign valid_in_s = g_stg[k-1].valid_r;
            assign carry_in_s = g_stg[k-1].carry_r;
            assign word_in_s  = g_stg[k-1].word_r;
            assign b_in_s     = g_stg[k-1].g_mid.b_r;
        end

        assign cy_s[0] = carry_in_s;
        for (genvar j = 0; j < BLK_PER_STG; j++) begin : g_blk
            csa_pipelined_adder_block #(.BLOCK(BLOCK)) u_blk (
                .a    (word_in_s[LO + j*BLOCK +: BLOCK]),
                .b    (b_in_s[j*BLOCK +: BLOCK]),
                .cin  (cy_s[j]),
                .sum  (stg_sum_s[j*BLOCK +: BLOCK]),
                .cout (cy_s[j+1])
            );
        end

        // Splice this stage's finished slice over the operand-a bits it consumed.
        always_comb begin
            word_d_s          = word_in_s;
            word_d_s[LO +: SW] = stg_sum_s;
        end

        // Stage register: valid, finished/pending word and carry into the next slice.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_r <= 1'b0;
                word_r  <= '0;
                carry_r <= 1'b0;
            end else if (adv_s) begin
                valid_r <= valid_in_s;
                word_r  <= word_d_s;
                carry_r <= cy_s[BLK_PER_STG];
            end else begin
                valid_r <= valid_r;
                word_r  <= word_r;
                carry_r <= carry_r;
            end
        end

        if (k < STAGES - 1) begin : g_mid
            logic [REM-SW-1:0] b_r;

            // Pending operand-b bits for the stages still ahead.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    b_r <= '0;
                end else if (adv_s) begin
                    b_r <= b_in_s[REM-1:SW];
                end else begin
                    b_r <= b_r;
                end
            end
        end else begin : g_last
            logic ovf_r;

            // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (adv_s) begin
                    ovf_r <= cy_s[BLK_PER_STG] ^ stg_sum_s[SW-1] ^ word_in_s[WIDTH-1] ^ b_in_s[REM-1];
                end else begin
                    ovf_r <= ovf_r;
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].valid_r;
    assign sum       = g_stg[STAGES-1].word_r;
    assign c_out     = g_stg[STAGES-1].carry_r;
    assign ovf       = g_stg[STAGES-1].g_last.ovf_r;

endmodule
